// File: rtl/lambdagen_s1.sv
// lambdagen_s1: triangle setup stage 1 -- edge deltas, degenerate-triangle cull,
// input FIFO and a stall-aware output register stage.
module lambdagen_s1 #(
  parameter int ZWIDTH  = 16,
  parameter int XWIDTH  = 9,
  parameter int YWIDTH  = 8,
  parameter int IDWIDTH = 16,
  parameter int DEPTH   = 4,
  parameter int CWIDTH  = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [XWIDTH-1:0]         x1_in,
  input  logic [XWIDTH-1:0]         x2_in,
  input  logic [XWIDTH-1:0]         x3_in,
  input  logic [YWIDTH-1:0]         y1_in,
  input  logic [YWIDTH-1:0]         y2_in,
  input  logic [YWIDTH-1:0]         y3_in,
  input  logic [ZWIDTH-1:0]         z1_in,
  input  logic [ZWIDTH-1:0]         z2_in,
  input  logic [ZWIDTH-1:0]         z3_in,
  input  logic [IDWIDTH-1:0]        tID_in,
  input  logic                      stall,
  output logic                      valid,
  output logic [XWIDTH:0]           dl1x_s1,
  output logic [XWIDTH:0]           dl2x_s1,
  output logic [YWIDTH:0]           dl1y_s1,
  output logic [YWIDTH:0]           dl2y_s1,
  output logic [XWIDTH-1:0]         x1_s1,
  output logic [XWIDTH-1:0]         x2_s1,
  output logic [YWIDTH-1:0]         y1_s1,
  output logic [YWIDTH-1:0]         y2_s1,
  output logic [ZWIDTH-1:0]         z1_s1,
  output logic [ZWIDTH-1:0]         z2_s1,
  output logic [ZWIDTH-1:0]         z3_s1,
  output logic [IDWIDTH-1:0]        tID_s1,
  output logic [CWIDTH-1:0]         cull_count,
  output logic [$clog2(DEPTH):0]    fifo_level
);
  localparam int AW = $clog2(DEPTH);
  logic [AW-1:0] wp, rp;
  logic [XWIDTH:0] d1x, d2x;
  logic [YWIDTH:0] d1y, d2y;
  logic acc, cull, push, pop;
  logic [XWIDTH:0]  m_d1x [DEPTH];
  logic [XWIDTH:0]  m_d2x [DEPTH];
  logic [YWIDTH:0]  m_d1y [DEPTH];
  logic [YWIDTH:0]  m_d2y [DEPTH];
  logic [XWIDTH-1:0] m_x1 [DEPTH];
  logic [XWIDTH-1:0] m_x2 [DEPTH];
  logic [YWIDTH-1:0] m_y1 [DEPTH];
  logic [YWIDTH-1:0] m_y2 [DEPTH];
  logic [ZWIDTH-1:0] m_z1 [DEPTH];
  logic [ZWIDTH-1:0] m_z2 [DEPTH];
  logic [ZWIDTH-1:0] m_z3 [DEPTH];
  logic [IDWIDTH-1:0] m_id [DEPTH];
  // one extra bit on each operand keeps the two's-complement difference exact
  assign d1x = {1'b0, x2_in} - {1'b0, x1_in};
  assign d2x = {1'b0, x3_in} - {1'b0, x2_in};
  assign d1y = {1'b0, y2_in} - {1'b0, y1_in};
  assign d2y = {1'b0, y3_in} - {1'b0, y2_in};
  assign in_ready = fifo_level != (AW+1)'(DEPTH);
  assign acc = in_valid && in_ready;
  assign cull = acc && ((d1x == '0 && d1y == '0) || (d2x == '0 && d2y == '0));
  assign push = acc && !cull;
  assign pop = !stall && fifo_level != '0;
  always_ff @(posedge clk) begin
    if (push) begin
      m_d1x[wp] <= d1x;
      m_d2x[wp] <= d2x;
      m_d1y[wp] <= d1y;
      m_d2y[wp] <= d2y;
      m_x1[wp] <= x1_in;
      m_x2[wp] <= x2_in;
      m_y1[wp] <= y1_in;
      m_y2[wp] <= y2_in;
      m_z1[wp] <= z1_in;
      m_z2[wp] <= z2_in;
      m_z3[wp] <= z3_in;
      m_id[wp] <= tID_in;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
      fifo_level <= '0;
      cull_count <= '0;
    end else begin
      wp <= wp + AW'(push);
      rp <= rp + AW'(pop);
      fifo_level <= fifo_level + (AW+1)'(push) - (AW+1)'(pop);
      if (cull && cull_count != '1) cull_count <= cull_count + CWIDTH'(1);
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      dl1x_s1 <= '0;
      dl2x_s1 <= '0;
      dl1y_s1 <= '0;
      dl2y_s1 <= '0;
      x1_s1 <= '0;
      x2_s1 <= '0;
      y1_s1 <= '0;
      y2_s1 <= '0;
      z1_s1 <= '0;
      z2_s1 <= '0;
      z3_s1 <= '0;
      tID_s1 <= '0;
    end else begin
      valid <= pop;
      if (pop) begin
        dl1x_s1 <= m_d1x[rp];
        dl2x_s1 <= m_d2x[rp];
        dl1y_s1 <= m_d1y[rp];
        dl2y_s1 <= m_d2y[rp];
        x1_s1 <= m_x1[rp];
        x2_s1 <= m_x2[rp];
        y1_s1 <= m_y1[rp];
        y2_s1 <= m_y2[rp];
        z1_s1 <= m_z1[rp];
        z2_s1 <= m_z2[rp];
        z3_s1 <= m_z3[rp];
        tID_s1 <= m_id[rp];
      end
    end
  end
endmodule
